kernel3_gmem_a_m_axi_buf_fifo: RTL and testbench

//   Valid/ready first-word-fall-through FIFO controller for the gmem_A m_axi read-data / write-data path.

---
 rtl/kernel3_gmem_a_buf_pkg.sv | 14 +
 rtl/kernel3_gmem_a_m_axi_buf_fifo_if.sv | 14 +
 rtl/kernel3_gmem_A_m_axi_mem.sv | 43 ++++
 rtl/kernel3_gmem_a_m_axi_buf_fifo.sv | 110 +++++++++++
 tb/tb_kernel3_gmem_a_m_axi_buf_fifo.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/kernel3_gmem_a_buf_pkg.sv
// Shared constants, default-geometry types and pointer helper for the gmem_A buffered FIFO.
package kernel3_gmem_a_buf_pkg;

    localparam int unsigned OBUF_DEPTH = 3;
    localparam int unsigned PTR_WIDTH  = 6;

    typedef logic [PTR_WIDTH-1:0] ptr_t;
    typedef logic [PTR_WIDTH:0]   cnt_t;

    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned depth);
        return (v == depth - 1) ? 32'd0 : v + 32'd1;
    endfunction

endpackage

// File: rtl/kernel3_gmem_a_m_axi_buf_fifo_if.sv
// Valid/ready write side and read side of the gmem_A buffered FIFO.
interface kernel3_gmem_a_m_axi_buf_fifo_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport slave  (input  s_valid, s_data, m_ready, output s_ready, m_valid, m_data);
    modport master (output s_valid, s_data, m_ready, input  s_ready, m_valid, m_data);
endinterface

// File: rtl/kernel3_gmem_A_m_axi_mem.sv
// Simple dual-port RAM: one write port, one read port with registered data (address registered by the caller).
module kernel3_gmem_A_m_axi_mem #(
    parameter string       MEM_STYLE  = "auto",
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  clk_en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] dout
);
    // The attribute must sit on the array declaration, hence one branch per style.
    if (MEM_STYLE == "block") begin : g_block
        (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            if (clk_en) begin
                if (we) mem[waddr] <= din;
                if (re) dout <= mem[raddr];
            end
        end
    end else if (MEM_STYLE == "distributed") begin : g_dist
        (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            if (clk_en) begin
                if (we) mem[waddr] <= din;
                if (re) dout <= mem[raddr];
            end
        end
    end else begin : g_auto
        (* ram_style = "auto" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            if (clk_en) begin
                if (we) mem[waddr] <= din;
                if (re) dout <= mem[raddr];
            end
        end
    end
endmodule

// File: rtl/kernel3_gmem_a_m_axi_buf_fifo.sv
// FWFT valid/ready FIFO over a 2-cycle-latency RAM, with a 3-entry output buffer for full throughput.
// Optional KERNEL3_GMEM_A_BUF_USEDW_EN adds a registered occupancy output usedw.
module kernel3_gmem_a_m_axi_buf_fifo
    import kernel3_gmem_a_buf_pkg::*;
#(
    parameter string       MEM_STYLE  = "auto",
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DEPTH      = 64
) (
    input  logic clk,
    input  logic reset,
    kernel3_gmem_a_m_axi_buf_fifo_if.slave bus
`ifdef KERNEL3_GMEM_A_BUF_USEDW_EN
    , output logic [ADDR_WIDTH+1:0] usedw
`endif
);
    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [ADDR_WIDTH:0]   count_t;

    localparam count_t     RAM_FULL  = count_t'(DEPTH);
    localparam logic [2:0] OBUF_FULL = 3'(OBUF_DEPTH);

    addr_t                 wptr, rptr, raddr_q;
    count_t                ram_cnt;
    logic [1:0]            obuf_cnt, inflight, wr_idx;
    logic                  re_q, dval_q;
    logic                  push, pop, issue;
    logic [2:0]            occ_after_pop;
    logic [DATA_WIDTH-1:0] ram_dout;
    logic [DATA_WIDTH-1:0] obuf [OBUF_DEPTH];

    assign bus.s_ready = !reset && (ram_cnt < RAM_FULL);
    assign bus.m_valid = (obuf_cnt != '0);
    assign bus.m_data  = obuf[0];

    // A read may issue only if its word will have a buffer slot when it lands.
    always_comb begin
        push          = bus.s_valid && bus.s_ready;
        pop           = bus.m_valid && bus.m_ready;
        occ_after_pop = 3'(obuf_cnt) + 3'(inflight) - 3'(pop);
        issue         = (ram_cnt != '0) && (occ_after_pop < OBUF_FULL);
        wr_idx        = obuf_cnt - 2'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            raddr_q  <= '0;
            ram_cnt  <= '0;
            inflight <= '0;
            re_q     <= 1'b0;
            dval_q   <= 1'b0;
        end else begin
            if (push) wptr <= addr_t'(wrap_inc(32'(wptr), DEPTH));
            if (issue) begin
                rptr    <= addr_t'(wrap_inc(32'(rptr), DEPTH));
                raddr_q <= rptr;
            end
            ram_cnt  <= ram_cnt + count_t'(push) - count_t'(issue);
            inflight <= inflight + 2'(issue) - 2'(dval_q);
            re_q     <= issue;
            dval_q   <= re_q;
        end
    end

    // Shift only occupied entries so the head holds its value when the last word leaves.
    always_ff @(posedge clk) begin
        if (reset) begin
            obuf_cnt <= '0;
            for (int unsigned i = 0; i < OBUF_DEPTH; i++) obuf[i] <= '0;
        end else begin
            obuf_cnt <= obuf_cnt - 2'(pop) + 2'(dval_q);
            if (pop) begin
                for (int unsigned i = 0; i + 1 < OBUF_DEPTH; i++) begin
                    if (i + 1 < 32'(obuf_cnt)) obuf[i] <= obuf[i+1];
                end
            end
            if (dval_q) obuf[wr_idx] <= ram_dout;
        end
    end

    kernel3_gmem_A_m_axi_mem #(
        .MEM_STYLE  (MEM_STYLE),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk    (clk),
        .clk_en (1'b1),
        .we     (push),
        .waddr  (wptr),
        .din    (bus.s_data),
        .re     (re_q && !reset),
        .raddr  (raddr_q),
        .dout   (ram_dout)
    );

`ifdef KERNEL3_GMEM_A_BUF_USEDW_EN
    typedef logic [ADDR_WIDTH+1:0] usedw_t;

    // Issues only move words between RAM and buffer, so push/pop alone track ram_cnt+inflight+obuf_cnt.
    always_ff @(posedge clk) begin
        if (reset) usedw <= '0;
        else       usedw <= usedw + usedw_t'(push) - usedw_t'(pop);
    end
`endif

endmodule

// File: tb/tb_kernel3_gmem_a_m_axi_buf_fifo.sv
// Directed + randomized bench for kernel3_gmem_a_m_axi_buf_fifo against a queue reference model.
module tb_kernel3_gmem_a_m_axi_buf_fifo;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 6;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned CAP   = DEPTH + 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    kernel3_gmem_a_m_axi_buf_fifo_if #(.DATA_WIDTH(DW)) bus ();

`ifdef KERNEL3_GMEM_A_BUF_USEDW_EN
    logic [AW+1:0] usedw;
`endif

    kernel3_gmem_a_m_axi_buf_fifo #(
        .MEM_STYLE  ("auto"),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef KERNEL3_GMEM_A_BUF_USEDW_EN
        , .usedw (usedw)
`endif
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] model [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, settle handshakes against the model, advance to edge+1.
    task automatic tick(input logic sv, input logic [31:0] sd, input logic mr);
        logic push, pop;
        bus.s_valid = sv;
        bus.s_data  = sd;
        bus.m_ready = mr;
        push = sv && bus.s_ready;
        pop  = bus.m_valid && mr;
        if (bus.m_valid) check("valid_implies_data", 64'(model.size() != 0), 64'd1);
        if (model.size() >= CAP) check("no_overfill", bus.s_ready, 0);
        if (pop && model.size() != 0) check("pop_data", bus.m_data, model.pop_front());
        if (push) model.push_back(sd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned acc, rise, guard, nxt, seq;
        logic        acc_now;

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_data",  bus.m_data,  0);
        check("rst_s_ready", bus.s_ready, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_s_ready", bus.s_ready, 1);

        // 1: single word latency
        tick(1'b1, 32'hA5A5_0001, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            check("t1_latency_valid", bus.m_valid, 0);
            tick(1'b0, '0, 1'b1);
        end
        check("t1_valid_c4", bus.m_valid, 1);
        check("t1_data_c4",  bus.m_data,  32'hA5A5_0001);
        tick(1'b0, '0, 1'b1);
        check("t1_valid_c5", bus.m_valid, 0);

        // 2: streaming without bubbles
        for (int k = 0; k < 208; k++) begin
            if (k >= 4 && k <= 203) check("t2_no_bubble", bus.m_valid, 1);
            if (k < 200) check("t2_s_ready", bus.s_ready, 1);
            tick(k < 200, 32'(k), 1'b1);
        end
        check("t2_drained", 64'(model.size()), 0);

        // 3: fill to capacity, then drain
        acc = 0;
        guard = 0;
        while (bus.s_ready && guard < 200) begin
            acc++;
            tick(1'b1, $urandom, 1'b0);
            guard++;
        end
        check("t3_accepted", acc, CAP);
        repeat (5) tick(1'b1, $urandom, 1'b0);
        check("t3_still_full", bus.s_ready, 0);
        check("t3_model_size", 64'(model.size()), CAP);
`ifdef KERNEL3_GMEM_A_BUF_USEDW_EN
        check("t3_usedw_full", usedw, CAP);
`endif
        guard = 0;
        while (model.size() != 0 && guard < 300) begin
            tick(1'b0, '0, 1'b1);
            guard++;
        end
        check("t3_drain_done", 64'(model.size()), 0);
        repeat (4) tick(1'b0, '0, 1'b1);
        check("t3_empty_after", bus.m_valid, 0);

        // 4: pointer wrap with random back-pressure
        for (int r = 0; r < 3; r++) begin
            nxt = 0;
            guard = 0;
            while (nxt < 50 && guard < 1000) begin
                acc_now = bus.s_ready;
                tick(1'b1, 32'h4000_0000 | (32'(r) << 16) | nxt, 1'($urandom_range(1)));
                if (acc_now) nxt++;
                guard++;
            end
            check("t4_pushed", nxt, 50);
            guard = 0;
            while (model.size() != 0 && guard < 1000) begin
                tick(1'b0, '0, 1'($urandom_range(1)));
                guard++;
            end
            check("t4_drained", 64'(model.size()), 0);
        end
        repeat (4) tick(1'b0, '0, 1'b1);
        check("t4_empty_after", bus.m_valid, 0);

        // 5: push+pop while full
        seq = 0;
        guard = 0;
        while (bus.s_ready && guard < 200) begin
            tick(1'b1, 32'h5000_0000 | seq, 1'b0);
            seq++;
            guard++;
        end
        check("t5_full", 64'(model.size()), CAP);
        rise = 0;
        for (int j = 0; j < 20; j++) begin
            if (j > 0 && rise == 0 && bus.s_ready) rise = j;
            acc_now = bus.s_ready;
            tick(1'b1, 32'h5000_0000 | seq, 1'b1);
            if (acc_now) seq++;
        end
        check("t5_s_ready_rise", 64'(rise >= 1 && rise <= 3), 1);
        guard = 0;
        while (model.size() != 0 && guard < 300) begin
            tick(1'b0, '0, 1'b1);
            guard++;
        end
        check("t5_drained", 64'(model.size()), 0);
        repeat (4) tick(1'b0, '0, 1'b1);
        check("t5_empty_after", bus.m_valid, 0);

        // 6: reset with words stored and reads in flight
        for (int k = 0; k < 14; k++) tick(1'b1, 32'h6000_0000 | 32'(k), 1'b0);
        tick(1'b0, '0, 1'b1);
        tick(1'b0, '0, 1'b1);
        reset       = 1'b1;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        @(posedge clk);
        #1;
        check("t6_valid_after_rst", bus.m_valid, 0);
        check("t6_s_ready_in_rst",  bus.s_ready, 0);
        reset = 1'b0;
        model.delete();
        @(posedge clk);
        #1;
        tick(1'b1, 32'h0000_1234, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            check("t6_latency_valid", bus.m_valid, 0);
            tick(1'b0, '0, 1'b0);
        end
        check("t6_valid_c4", bus.m_valid, 1);
        check("t6_data_c4",  bus.m_data,  32'h0000_1234);
`ifdef KERNEL3_GMEM_A_BUF_USEDW_EN
        check("t6_usedw", usedw, 1);
`endif
        tick(1'b0, '0, 1'b0);
        check("t6_hold_valid", bus.m_valid, 1);
        check("t6_hold_data",  bus.m_data,  32'h0000_1234);
        tick(1'b0, '0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            check("t6_alone", bus.m_valid, 0);
            tick(1'b0, '0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
